// File: rtl/regbank_access_arbiter.sv
// regbank_access_arbiter
// Arbitrates the CPU microcode port (A) and the debug/load port (B) onto the
// 8x8-bit register bank (B C D E H L W Z). The bank has a single 8-bit write
// port, so a 16-bit write is issued as two byte writes: even (high) register
// first, then odd (low) register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; arbitration and latching happen here
// ACC1  | first bank access (read capture, byte write, or high-byte write)
// ACC2  | second bank access, low-byte write of a 16-bit write only
// ACK   | one-cycle ack pulse to the granted requester
module regbank_access_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_a_req,
  input  logic [1:0]  i_a_op,
  input  logic [2:0]  i_a_addr,
  input  logic [15:0] i_a_wdata,
  output logic        o_a_ack,
  output logic [15:0] o_a_rdata,
  input  logic        i_b_req,
  input  logic [1:0]  i_b_op,
  input  logic [2:0]  i_b_addr,
  input  logic [15:0] i_b_wdata,
  output logic        o_b_ack,
  output logic [15:0] o_b_rdata,
  output logic [2:0]  o_bank_reg_num,
  output logic [7:0]  o_bank_data_in,
  output logic        o_bank_we,
  input  logic [7:0]  i_bank_data_out,
  input  logic [15:0] i_bank_data_out16,
  output logic        o_busy
);

  localparam logic [1:0] OP_RD8  = 2'b00;
  localparam logic [1:0] OP_WR8  = 2'b01;
  localparam logic [1:0] OP_RD16 = 2'b10;
  localparam logic [1:0] OP_WR16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_last_b;      // 1 = B was granted last
  logic        r_gnt_b;       // 1 = current transaction belongs to B
  logic [1:0]  r_op;
  logic [7:0]  r_wdata_lo;    // low byte kept for the second half of a write16
  logic [2:0]  r_reg_num;
  logic [7:0]  r_data_in;
  logic [15:0] r_a_rdata;
  logic [15:0] r_b_rdata;

  logic        w_any_req;
  logic        w_grant_b;
  logic [1:0]  w_sel_op;
  logic [2:0]  w_sel_addr;
  logic [15:0] w_sel_wdata;
  logic        w_grant;
  logic        w_we;
  logic        w_ack;
  logic        w_cap8;
  logic        w_cap16;
  logic [15:0] w_cap_val;

  // Pick the winner when both ask: round-robin alternates, fixed priority favours A.
  always_comb begin
    w_any_req = i_a_req | i_b_req;
    w_grant_b = i_b_req & (~i_a_req | (RR_ENABLE & ~r_last_b));
    if (w_grant_b) begin
      w_sel_op    = i_b_op;
      w_sel_addr  = i_b_addr;
      w_sel_wdata = i_b_wdata;
    end else begin
      w_sel_op    = i_a_op;
      w_sel_addr  = i_a_addr;
      w_sel_wdata = i_a_wdata;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_we        = 1'b0;
    w_ack       = 1'b0;
    w_cap8      = 1'b0;
    w_cap16     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ACC1;
        end
      end
      ST_ACC1: begin
        w_state_nxt = ST_ACK;
        case (r_op)
          OP_RD8:  w_cap8  = 1'b1;
          OP_WR8:  w_we    = 1'b1;
          OP_RD16: w_cap16 = 1'b1;
          OP_WR16: begin
            w_we        = 1'b1;
            w_state_nxt = ST_ACC2;
          end
        endcase
      end
      ST_ACC2: begin
        w_we        = 1'b1;
        w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Latch the granted transaction; later input changes are ignored until IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_b   <= 1'b1;
      r_gnt_b    <= 1'b0;
      r_op       <= OP_RD8;
      r_wdata_lo <= 8'h00;
    end else if (w_grant) begin
      r_last_b   <= w_grant_b;
      r_gnt_b    <= w_grant_b;
      r_op       <= w_sel_op;
      r_wdata_lo <= w_sel_wdata[7:0];
    end
  end

  // Bank address/data are set up at grant so they are stable for all of ACC1,
  // advance to the odd register for ACC2, and otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg_num <= 3'd0;
      r_data_in <= 8'h00;
    end else if (w_grant) begin
      case (w_sel_op)
        OP_RD8:  r_reg_num <= w_sel_addr;
        OP_WR8: begin
          r_reg_num <= w_sel_addr;
          r_data_in <= w_sel_wdata[7:0];
        end
        OP_RD16: r_reg_num <= {w_sel_addr[2:1], 1'b0};
        OP_WR16: begin
          r_reg_num <= {w_sel_addr[2:1], 1'b0};
          r_data_in <= w_sel_wdata[15:8];
        end
      endcase
    end else if (r_state == ST_ACC1 && r_op == OP_WR16) begin
      r_reg_num <= {r_reg_num[2:1], 1'b1};
      r_data_in <= r_wdata_lo;
    end
  end

  assign w_cap_val = w_cap16 ? i_bank_data_out16 : {8'h00, i_bank_data_out};

  // Read results land in the granted requester's holding register at the end of ACC1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a_rdata <= 16'h0000;
      r_b_rdata <= 16'h0000;
    end else if (w_cap8 || w_cap16) begin
      if (r_gnt_b) r_b_rdata <= w_cap_val;
      else         r_a_rdata <= w_cap_val;
    end
  end

  // Write enable is suppressed during reset so an aborted write16 cannot
  // complete its second byte.
  assign o_bank_we      = reset & w_we;
  assign o_bank_reg_num = r_reg_num;
  assign o_bank_data_in = r_data_in;
  assign o_a_ack        = w_ack & ~r_gnt_b;
  assign o_b_ack        = w_ack & r_gnt_b;
  assign o_a_rdata      = r_a_rdata;
  assign o_b_rdata      = r_b_rdata;
  assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Bench for regbank_access_arbiter: instance 0 round-robin, instance 1 fixed
// priority, each with a simple behavioural register bank attached. Results are
// compared with a transaction-level model of the register file.
module tb_regbank_access_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_req [2];
  logic [1:0]  a_op [2];
  logic [2:0]  a_addr [2];
  logic [15:0] a_wdata [2];
  logic        a_ack [2];
  logic [15:0] a_rdata [2];
  logic        b_req [2];
  logic [1:0]  b_op [2];
  logic [2:0]  b_addr [2];
  logic [15:0] b_wdata [2];
  logic        b_ack [2];
  logic [15:0] b_rdata [2];
  logic [2:0]  bank_rn [2];
  logic [7:0]  bank_din [2];
  logic        bank_we [2];
  logic [7:0]  bank_do [2];
  logic [15:0] bank_do16 [2];
  logic        busy [2];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0]  ref_regs [2][8];
  logic [15:0] ref_rd [2][2];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_inst
    logic [7:0] mem [8];

    regbank_access_arbiter #(.RR_ENABLE((k == 0) ? 1'b1 : 1'b0)) dut (
      .clk               (clk),
      .reset             (reset),
      .i_a_req           (a_req[k]),
      .i_a_op            (a_op[k]),
      .i_a_addr          (a_addr[k]),
      .i_a_wdata         (a_wdata[k]),
      .o_a_ack           (a_ack[k]),
      .o_a_rdata         (a_rdata[k]),
      .i_b_req           (b_req[k]),
      .i_b_op            (b_op[k]),
      .i_b_addr          (b_addr[k]),
      .i_b_wdata         (b_wdata[k]),
      .o_b_ack           (b_ack[k]),
      .o_b_rdata         (b_rdata[k]),
      .o_bank_reg_num    (bank_rn[k]),
      .o_bank_data_in    (bank_din[k]),
      .o_bank_we         (bank_we[k]),
      .i_bank_data_out   (bank_do[k]),
      .i_bank_data_out16 (bank_do16[k]),
      .o_busy            (busy[k])
    );

    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      end else if (bank_we[k] === 1'b1) begin
        mem[bank_rn[k]] <= bank_din[k];
      end
    end

    assign bank_do[k]   = mem[bank_rn[k]];
    assign bank_do16[k] = {mem[{bank_rn[k][2:1], 1'b0}], mem[{bank_rn[k][2:1], 1'b1}]};
  end

  function automatic logic [7:0] mem_rd(input int inst, input int idx);
    if (inst == 0) return g_inst[0].mem[idx];
    return g_inst[1].mem[idx];
  endfunction

  function automatic logic ack_of(input int inst, input int who);
    return (who == 0) ? a_ack[inst] : b_ack[inst];
  endfunction

  function automatic logic [15:0] rdata_of(input int inst, input int who);
    return (who == 0) ? a_rdata[inst] : b_rdata[inst];
  endfunction

  task automatic drive_req(input int inst, input int who, input logic req, input logic [1:0] op,
                           input logic [2:0] addr, input logic [15:0] wd);
    if (who == 0) begin
      a_req[inst] = req; a_op[inst] = op; a_addr[inst] = addr; a_wdata[inst] = wd;
    end else begin
      b_req[inst] = req; b_op[inst] = op; b_addr[inst] = addr; b_wdata[inst] = wd;
    end
  endtask

  // Register-file model: 16-bit ops address the pair, high byte in the even register.
  task automatic model_txn(input int inst, input int who, input logic [1:0] op, input logic [2:0] addr,
                           input logic [15:0] wd, output logic [15:0] exp_rd, output int exp_lat);
    int ev;
    ev = (addr / 2) * 2;
    case (op)
      2'b00: ref_rd[inst][who] = {8'h00, ref_regs[inst][addr]};
      2'b01: ref_regs[inst][addr] = wd[7:0];
      2'b10: ref_rd[inst][who] = {ref_regs[inst][ev], ref_regs[inst][ev + 1]};
      2'b11: begin
        ref_regs[inst][ev]     = wd[15:8];
        ref_regs[inst][ev + 1] = wd[7:0];
      end
    endcase
    exp_rd  = ref_rd[inst][who];
    exp_lat = (op == 2'b11) ? 2 : 1;
  endtask

  // Issue one request and wait (bounded) for its ack; waited = -1 on timeout.
  task automatic txn(input int inst, input int who, input logic [1:0] op, input logic [2:0] addr,
                     input logic [15:0] wd, output int waited, output logic [15:0] rd);
    @(negedge clk);
    drive_req(inst, who, 1'b1, op, addr, wd);
    waited = -1;
    rd = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_of(inst, who) === 1'b1) begin
        waited = i;
        rd = rdata_of(inst, who);
        break;
      end
    end
    @(posedge clk);
    #1;
    drive_req(inst, who, 1'b0, op, addr, wd);
  endtask

  // Issue one request and log bank activity for 8 cycles after it is sampled.
  task automatic mon_txn(input int inst, input int who, input logic [1:0] op, input logic [2:0] addr,
                         input logic [15:0] wd, input bit perturb,
                         output int ack_at, output logic [7:0] we_pat, output logic [7:0] busy_pat,
                         output logic [7:0] ack_pat, output logic [23:0] rn_log,
                         output logic [63:0] din_log, output logic [15:0] rd);
    ack_at = -1; we_pat = '0; busy_pat = '0; ack_pat = '0; rn_log = '0; din_log = '0; rd = '0;
    @(negedge clk);
    drive_req(inst, who, 1'b1, op, addr, wd);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      we_pat[i]          = bank_we[inst];
      busy_pat[i]        = busy[inst];
      ack_pat[i]         = ack_of(inst, who);
      rn_log[i*3 +: 3]   = bank_rn[inst];
      din_log[i*8 +: 8]  = bank_din[inst];
      if (perturb && i == 0) drive_req(inst, who, 1'b1, ~op, ~addr, ~wd);
      if (ack_of(inst, who) === 1'b1 && ack_at < 0) begin
        ack_at = i;
        rd = rdata_of(inst, who);
        @(posedge clk);
        #1;
        drive_req(inst, who, 1'b0, op, addr, wd);
      end
    end
    if (ack_at < 0) drive_req(inst, who, 1'b0, op, addr, wd);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({a_ack[k], b_ack[k], bank_we[k], busy[k]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ctl inst%0d: a_ack/b_ack/we/busy got %b expected 0000", k,
                 {a_ack[k], b_ack[k], bank_we[k], busy[k]});
      end
      n_tests++;
      if ({a_rdata[k], b_rdata[k], bank_rn[k], bank_din[k]} !== 43'd0) begin
        n_fail++;
        $display("FAIL reset_data inst%0d: a_rdata=%h b_rdata=%h rn=%0d din=%h expected all zero", k,
                 a_rdata[k], b_rdata[k], bank_rn[k], bank_din[k]);
      end
      for (int i = 0; i < 8; i++) ref_regs[k][i] = 8'h00;
      ref_rd[k][0] = 16'h0000;
      ref_rd[k][1] = 16'h0000;
    end
    reset = 1'b1;
  endtask

  task automatic test_write8_read8();
    int ack_at, w, lat;
    logic [7:0] we_pat, busy_pat, ack_pat;
    logic [23:0] rn_log;
    logic [63:0] din_log;
    logic [15:0] rd, exp;
    mon_txn(0, 0, 2'b01, 3'd3, 16'h005A, 1'b0, ack_at, we_pat, busy_pat, ack_pat, rn_log, din_log, rd);
    model_txn(0, 0, 2'b01, 3'd3, 16'h005A, exp, lat);
    n_tests++;
    if (we_pat !== 8'b0000_0001 || rn_log[2:0] !== 3'd3 || din_log[7:0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL w8_bank: we_pat=%b rn=%0d din=%h expected we_pat=00000001 rn=3 din=5a",
               we_pat, rn_log[2:0], din_log[7:0]);
    end
    n_tests++;
    if (ack_at !== 1 || ack_pat !== 8'b0000_0010 || busy_pat !== 8'b0000_0011) begin
      n_fail++;
      $display("FAIL w8_timing: ack_at=%0d ack_pat=%b busy_pat=%b expected 1 00000010 00000011",
               ack_at, ack_pat, busy_pat);
    end
    txn(0, 0, 2'b00, 3'd3, 16'hFFFF, w, rd);
    model_txn(0, 0, 2'b00, 3'd3, 16'hFFFF, exp, lat);
    n_tests++;
    if (rd !== exp || w !== lat) begin
      n_fail++;
      $display("FAIL r8: rdata=%h lat=%0d expected rdata=%h lat=%0d", rd, w, exp, lat);
    end
  endtask

  task automatic test_write16();
    int ack_at, w, lat;
    logic [7:0] we_pat, busy_pat, ack_pat;
    logic [23:0] rn_log;
    logic [63:0] din_log;
    logic [15:0] rd, exp;
    mon_txn(0, 0, 2'b11, 3'd5, 16'h1234, 1'b0, ack_at, we_pat, busy_pat, ack_pat, rn_log, din_log, rd);
    model_txn(0, 0, 2'b11, 3'd5, 16'h1234, exp, lat);
    n_tests++;
    if (we_pat !== 8'b0000_0011 || rn_log[5:0] !== {3'd5, 3'd4} || din_log[15:0] !== 16'h3412) begin
      n_fail++;
      $display("FAIL w16_bank: we_pat=%b rn1=%0d rn2=%0d din1=%h din2=%h expected 00000011 4 5 12 34",
               we_pat, rn_log[2:0], rn_log[5:3], din_log[7:0], din_log[15:8]);
    end
    n_tests++;
    if (ack_at !== 2 || ack_pat !== 8'b0000_0100 || busy_pat !== 8'b0000_0111) begin
      n_fail++;
      $display("FAIL w16_timing: ack_at=%0d ack_pat=%b busy_pat=%b expected 2 00000100 00000111",
               ack_at, ack_pat, busy_pat);
    end
    n_tests++;
    if (mem_rd(0, 4) !== ref_regs[0][4] || mem_rd(0, 5) !== ref_regs[0][5]) begin
      n_fail++;
      $display("FAIL w16_mem: reg4=%h reg5=%h expected %h %h", mem_rd(0, 4), mem_rd(0, 5),
               ref_regs[0][4], ref_regs[0][5]);
    end
    txn(0, 0, 2'b10, 3'd4, 16'h0000, w, rd);
    model_txn(0, 0, 2'b10, 3'd4, 16'h0000, exp, lat);
    n_tests++;
    if (rd !== exp || w !== lat) begin
      n_fail++;
      $display("FAIL r16: rdata=%h lat=%0d expected rdata=%h lat=%0d", rd, w, exp, lat);
    end
  endtask

  task automatic test_b_pair();
    int ack_at, w, lat;
    logic [7:0] we_pat, busy_pat, ack_pat;
    logic [23:0] rn_log;
    logic [63:0] din_log;
    logic [15:0] rd, exp;
    txn(0, 0, 2'b01, 3'd6, 16'h00AB, w, rd);
    model_txn(0, 0, 2'b01, 3'd6, 16'h00AB, exp, lat);
    txn(0, 0, 2'b01, 3'd7, 16'h00CD, w, rd);
    model_txn(0, 0, 2'b01, 3'd7, 16'h00CD, exp, lat);
    mon_txn(0, 1, 2'b10, 3'd7, 16'h0000, 1'b0, ack_at, we_pat, busy_pat, ack_pat, rn_log, din_log, rd);
    model_txn(0, 1, 2'b10, 3'd7, 16'h0000, exp, lat);
    n_tests++;
    if (rd !== exp || b_rdata[0] !== exp) begin
      n_fail++;
      $display("FAIL b_r16: rdata=%h held=%h expected %h", rd, b_rdata[0], exp);
    end
    n_tests++;
    if (a_rdata[0] !== ref_rd[0][0]) begin
      n_fail++;
      $display("FAIL b_r16_a_untouched: a_rdata=%h expected %h", a_rdata[0], ref_rd[0][0]);
    end
    n_tests++;
    if (ack_pat !== 8'b0000_0010 || we_pat !== 8'h00) begin
      n_fail++;
      $display("FAIL b_r16_ack: ack_pat=%b we_pat=%b expected 00000010 00000000", ack_pat, we_pat);
    end
  endtask

  task automatic test_arbitration(input int inst, input int n_a, input int n_b, input logic [3:0] exp_order);
    int order_q[$];
    logic [3:0] got;
    fork
      begin
        for (int n = 0; n < n_a; n++) begin
          int w; logic [15:0] rd;
          txn(inst, 0, 2'b00, 3'(n), 16'h0000, w, rd);
          order_q.push_back((w < 0) ? 2 : 0);
        end
      end
      begin
        for (int n = 0; n < n_b; n++) begin
          int w; logic [15:0] rd;
          txn(inst, 1, 2'b00, 3'(n + 4), 16'h0000, w, rd);
          order_q.push_back((w < 0) ? 2 : 1);
        end
      end
    join
    got = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < order_q.size()) got[i] = (order_q[i] == 1);
    end
    for (int n = 0; n < n_a; n++) ref_rd[inst][0] = {8'h00, ref_regs[inst][n]};
    for (int n = 0; n < n_b; n++) ref_rd[inst][1] = {8'h00, ref_regs[inst][n + 4]};
    n_tests++;
    if (order_q.size() != 4 || (2 inside {order_q}) || got !== exp_order) begin
      n_fail++;
      $display("FAIL arb_order inst%0d: grant bits (1=B, first in bit0)=%b count=%0d expected %b count=4",
               inst, got, order_q.size(), exp_order);
    end
  endtask

  task automatic test_reset_mid();
    int w, lat;
    logic [15:0] rd, exp;
    logic seen_ack;
    txn(0, 0, 2'b01, 3'd1, 16'h0077, w, rd);
    model_txn(0, 0, 2'b01, 3'd1, 16'h0077, exp, lat);
    txn(0, 0, 2'b01, 3'd0, 16'h0011, w, rd);
    model_txn(0, 0, 2'b01, 3'd0, 16'h0011, exp, lat);
    @(negedge clk);
    drive_req(0, 0, 1'b1, 2'b11, 3'd0, 16'hBEEF);
    @(negedge clk);
    seen_ack = a_ack[0];
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (bank_we[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_we_forced: bank_we=%b expected 0", bank_we[0]);
    end
    seen_ack = seen_ack | a_ack[0];
    @(negedge clk);
    n_tests++;
    if ({a_ack[0], b_ack[0], bank_we[0], busy[0], seen_ack} !== 5'b00000) begin
      n_fail++;
      $display("FAIL rst_mid_ctl: a_ack/b_ack/we/busy/ack_seen got %b expected 00000",
               {a_ack[0], b_ack[0], bank_we[0], busy[0], seen_ack});
    end
    n_tests++;
    if ({a_rdata[0], b_rdata[0], bank_rn[0], bank_din[0]} !== 43'd0) begin
      n_fail++;
      $display("FAIL rst_mid_data: a_rdata=%h b_rdata=%h rn=%0d din=%h expected all zero",
               a_rdata[0], b_rdata[0], bank_rn[0], bank_din[0]);
    end
    drive_req(0, 0, 1'b0, 2'b00, 3'd0, 16'h0000);
    reset = 1'b1;
    ref_regs[0][0] = 8'hBE;
    for (int k = 0; k < 2; k++) begin
      ref_rd[k][0] = 16'h0000;
      ref_rd[k][1] = 16'h0000;
    end
    n_tests++;
    if (mem_rd(0, 0) !== ref_regs[0][0] || mem_rd(0, 1) !== ref_regs[0][1]) begin
      n_fail++;
      $display("FAIL rst_mid_mem: reg0=%h reg1=%h expected %h %h", mem_rd(0, 0), mem_rd(0, 1),
               ref_regs[0][0], ref_regs[0][1]);
    end
    txn(0, 0, 2'b10, 3'd1, 16'h0000, w, rd);
    model_txn(0, 0, 2'b10, 3'd1, 16'h0000, exp, lat);
    n_tests++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL rst_mid_readback: rdata=%h expected %h", rd, exp);
    end
  endtask

  task automatic test_latch();
    int ack_at, w, lat;
    logic [7:0] we_pat, busy_pat, ack_pat;
    logic [23:0] rn_log;
    logic [63:0] din_log;
    logic [15:0] rd, exp;
    mon_txn(0, 0, 2'b11, 3'd2, 16'h55AA, 1'b1, ack_at, we_pat, busy_pat, ack_pat, rn_log, din_log, rd);
    model_txn(0, 0, 2'b11, 3'd2, 16'h55AA, exp, lat);
    n_tests++;
    if (we_pat !== 8'b0000_0011 || rn_log[5:0] !== {3'd3, 3'd2} || din_log[15:0] !== 16'hAA55
        || ack_at !== 2) begin
      n_fail++;
      $display("FAIL latch_bank: we_pat=%b rn1=%0d rn2=%0d din1=%h din2=%h ack_at=%0d expected 00000011 2 3 55 aa 2",
               we_pat, rn_log[2:0], rn_log[5:3], din_log[7:0], din_log[15:8], ack_at);
    end
    txn(0, 0, 2'b00, 3'd5, 16'h0000, w, rd);
    model_txn(0, 0, 2'b00, 3'd5, 16'h0000, exp, lat);
    n_tests++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL latch_ignored_addr: reg5 read=%h expected %h", rd, exp);
    end
    txn(0, 0, 2'b10, 3'd3, 16'h0000, w, rd);
    model_txn(0, 0, 2'b10, 3'd3, 16'h0000, exp, lat);
    n_tests++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL latch_readback: pair1 read=%h expected %h", rd, exp);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int inst, who, w, lat;
      logic [1:0] op;
      logic [2:0] addr;
      logic [15:0] wd, rd, exp;
      inst = int'($urandom_range(0, 1));
      who  = int'($urandom_range(0, 1));
      op   = 2'($urandom_range(0, 3));
      addr = 3'($urandom_range(0, 7));
      wd   = 16'($urandom);
      txn(inst, who, op, addr, wd, w, rd);
      model_txn(inst, who, op, addr, wd, exp, lat);
      n_tests++;
      if (w !== lat || (!op[0] && rd !== exp) || rdata_of(inst, who) !== exp) begin
        n_fail++;
        $display("FAIL rand[%0d] inst%0d who%0d op%0d addr%0d: lat=%0d rdata=%h expected lat=%0d rdata=%h",
                 n, inst, who, op, addr, w, rdata_of(inst, who), lat, exp);
      end
      n_tests++;
      if (rdata_of(inst, 1 - who) !== ref_rd[inst][1 - who]) begin
        n_fail++;
        $display("FAIL rand_other[%0d] inst%0d: other rdata=%h expected %h", n, inst,
                 rdata_of(inst, 1 - who), ref_rd[inst][1 - who]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      drive_req(k, 0, 1'b0, 2'b00, 3'd0, 16'h0000);
      drive_req(k, 1, 1'b0, 2'b00, 3'd0, 16'h0000);
    end
    test_reset();
    test_write8_read8();
    test_write16();
    test_b_pair();
    test_arbitration(0, 2, 2, 4'b1010);
    test_arbitration(1, 3, 1, 4'b1000);
    test_reset_mid();
    test_latch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "time limit");
  end

endmodule
